// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the RV32I hazard resolver: forwarding-select
// encodings and the default register-specifier width.
package hazard_unit_pkg;

  localparam int REG_AW_DEFAULT = 5;

  // ALU operand source selects driven on ForwardAE / ForwardBE
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB   = 2'b01;  // Writeback result
  localparam logic [1:0] FWD_MEM  = 2'b10;  // Memory-stage ALU result

endpackage : hazard_unit_pkg

// File: rtl/hazard_shadow_stage.sv
// One slice of the hazard unit's shadow pipeline: a W-bit register that
// resets to zero and, when CLR_EN is set, can be cleared to a bubble.
module hazard_shadow_stage #(
  parameter int W      = 1,
  parameter bit CLR_EN = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] slot_q;
  logic [W-1:0] slot_d;

  // A clear inserts a bubble: every field, including the enables, goes to 0
  always_comb begin
    slot_d = d_i;
    if (CLR_EN && clr_i) slot_d = '0;
  end

  // Slice register; reset wipes the whole slot
  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign q_o = slot_q;

endmodule : hazard_shadow_stage

// File: rtl/hazard_unit.sv
// Hazard resolver for the 5-stage RV32I pipeline. Tracks register specifiers
// through E/M/W, produces forwarding selects, load-use stalls and
// control-hazard flushes.
// Optional feature macro: HAZARD_PERF_CNT_EN enables saturating stall/flush
// event counters; without it StallCount/FlushCount read 0.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              RegWriteD,
  input  logic              LoadD,
  input  logic              PCSrcE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam int EW = 3 * REG_AW + 2;
  localparam int MW = REG_AW + 1;

  logic [REG_AW-1:0] Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteE, LoadE, RegWriteM, RegWriteW;
  logic              lw_stall;
  logic              flush_e_raw;

  // Pick the newest in-flight producer of src; Memory beats Writeback and
  // x0 is never a producer.
  function automatic logic [1:0] fwd_select(
    input logic [REG_AW-1:0] src,
    input logic              wr_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] rd_w
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    if (wr_m && (rd_m != '0) && (rd_m == src))      sel = FWD_MEM;
    else if (wr_w && (rd_w != '0) && (rd_w == src)) sel = FWD_WB;
    return sel;
  endfunction

  // E slot: loads the Decode operands, cleared to a bubble on FlushE
  hazard_shadow_stage #(.W(EW), .CLR_EN(1'b1)) u_stage_e (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush_e_raw),
    .d_i   ({Rs1D, Rs2D, RdD, RegWriteD, LoadD}),
    .q_o   ({Rs1E, Rs2E, RdE, RegWriteE, LoadE})
  );

  // M slot: follows E unconditionally
  hazard_shadow_stage #(.W(MW), .CLR_EN(1'b0)) u_stage_m (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .d_i   ({RdE, RegWriteE}),
    .q_o   ({RdM, RegWriteM})
  );

  // W slot: follows M unconditionally
  hazard_shadow_stage #(.W(MW), .CLR_EN(1'b0)) u_stage_w (
    .clk   (clk),
    .reset (reset),
    .clr_i (1'b0),
    .d_i   ({RdM, RegWriteM}),
    .q_o   ({RdW, RegWriteW})
  );

  assign ForwardAE = fwd_select(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
  assign ForwardBE = fwd_select(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

  // A load in E whose target is read by the Decode instruction cannot be
  // forwarded in time; hold F/D for one cycle and bubble E.
  assign lw_stall = LoadE && RegWriteE && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // A taken redirect discards the stalled instruction anyway, so it wins
  assign StallF      = lw_stall && !PCSrcE;
  assign StallD      = StallF;
  assign flush_e_raw = lw_stall || PCSrcE;
  assign FlushD      = PCSrcE && !reset;
  assign FlushE      = flush_e_raw && !reset;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Next counter values: bump on a stall cycle / a redirect cycle
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF) stall_cnt_d = sat_inc(stall_cnt_q);
    if (PCSrcE) flush_cnt_d = sat_inc(flush_cnt_q);
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule : hazard_unit
